// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding and constants for the core run controller
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CRST = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } run_state_e;

  localparam logic [31:0] HALT_INSTR  = 32'h0000_0073;
  localparam int          CRST_CYCLES = 2;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program stream handshake and registered imem write port
module imem_loader #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              ld_valid_i,
  input  logic [XLEN-1:0]   ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [XLEN-1:0]   imem_wdata_o,
  output logic [ADDR_W:0]   load_len_o,
  output logic              load_done_o
);

  logic              ld_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [XLEN-1:0]   imem_wdata_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   load_len_q;
  logic              accept;
  logic              final_word;

  assign accept     = ld_valid_i & ld_ready_q;
  // the top address ends the load even without ld_last so the pointer can never wrap
  assign final_word = ld_last_i | (&wr_ptr_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ld_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      wr_ptr_q     <= '0;
      load_len_q   <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (load_start_i) begin
        ld_ready_q <= 1'b1;
        wr_ptr_q   <= '0;
      end else if (accept) begin
        imem_we_q    <= 1'b1;
        imem_addr_q  <= wr_ptr_q;
        imem_wdata_q <= ld_data_i;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        if (final_word) begin
          ld_ready_q <= 1'b0;
          load_len_q <= {1'b0, wr_ptr_q} + 1'b1;
        end
      end
    end
  end

  assign ld_ready_o   = ld_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign load_len_o   = load_len_q;
  assign load_done_o  = accept & final_word;

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - loads a program, sequences core reset and gates core execution
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              ADDR_W     = 6,
  parameter int              CNT_W      = 16,
  parameter int              MAX_CYCLES = 1024,
  parameter logic [XLEN-1:0] HALT_INSTR = core_ctrl_pkg::HALT_INSTR
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              reload,
  input  logic              step_mode,
  input  logic              step,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  input  logic [XLEN-1:0]   core_instr,
  output logic              core_rst,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   load_len,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [1:0]       CRST_END = 2'(CRST_CYCLES - 1);

  run_state_e       state_q;
  logic             core_rst_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [1:0]       crst_cnt_q;

  logic idle_like;
  logic load_start;
  logic load_done;
  logic en_req;
  logic is_halt_instr;
  logic at_budget;
  logic core_en_w;

  assign idle_like     = (state_q == S_IDLE) || (state_q == S_HALT);
  assign load_start    = idle_like & start & reload;
  assign en_req        = step_mode ? step : 1'b1;
  assign is_halt_instr = (core_instr == HALT_INSTR);
  assign at_budget     = (cycle_cnt_q == MAX_CNT);
  // the halt opcode itself is never executed, and the budget caps cycle_cnt
  assign core_en_w     = (state_q == S_RUN) & en_req & ~is_halt_instr & ~at_budget;

  imem_loader #(
    .XLEN  (XLEN),
    .ADDR_W(ADDR_W)
  ) u_loader (
    .clk_i       (CLK),
    .rst_ni      (rst),
    .load_start_i(load_start),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_last_i   (ld_last),
    .ld_ready_o  (ld_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .load_len_o  (load_len),
    .load_done_o (load_done)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      crst_cnt_q  <= '0;
    end else begin
      if (core_en_w) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q     <= reload ? S_LOAD : S_CRST;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            crst_cnt_q  <= '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state_q    <= S_CRST;
            crst_cnt_q <= '0;
          end
        end
        S_CRST: begin
          cycle_cnt_q <= '0;
          if (crst_cnt_q == CRST_END) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
          end else begin
            crst_cnt_q <= crst_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if ((en_req & is_halt_instr) | at_budget) begin
            state_q    <= S_HALT;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= ~(en_req & is_halt_instr);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign core_en   = core_en_w;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - randomized self-checking bench for core_run_ctrl
module tb_core_run_ctrl;

  localparam int          XLEN    = 32;
  localparam int          ADDR_W  = 6;
  localparam int          CNT_W   = 16;
  localparam int          MAX_CYC = 40;
  localparam logic [31:0] HALT    = 32'h0000_0073;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              CLK = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              reload = 1'b0;
  logic              step_mode = 1'b0;
  logic              step = 1'b0;
  logic              ld_valid = 1'b0;
  logic [XLEN-1:0]   ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_wdata;
  logic [XLEN-1:0]   core_instr;
  logic              core_rst;
  logic              core_en;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [ADDR_W:0]   load_len;
  logic [CNT_W-1:0]  cycle_cnt;

  // environment: a simple imem and a core PC that walks it sequentially
  logic [31:0] mem [64];
  logic [5:0]  pc;
  logic        clr_mem = 1'b0;

  // reference model state
  logic [31:0] exp_mem [64];
  logic [31:0] pw [64];
  int          n_tests = 0;
  int          n_fail = 0;
  int          en_count = 0;
  int          en_base = 0;
  int          wr_cnt = 0;
  logic [5:0]  wr_addr_log [256];
  logic [31:0] wr_data_log [256];

  core_run_ctrl #(
    .XLEN      (XLEN),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .MAX_CYCLES(MAX_CYC),
    .HALT_INSTR(HALT)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .reload    (reload),
    .step_mode (step_mode),
    .step      (step),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_instr(core_instr),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .load_len  (load_len),
    .cycle_cnt (cycle_cnt)
  );

  always #5 CLK = ~CLK;

  assign core_instr = mem[pc];

  always @(posedge CLK) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= NOP;
    end else if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
    end
    if (core_rst) pc <= '0;
    else if (core_en) pc <= pc + 6'd1;
  end

  always @(negedge CLK) begin
    if (imem_we) begin
      wr_addr_log[wr_cnt % 256] <= imem_addr;
      wr_data_log[wr_cnt % 256] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (core_en) en_count <= en_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // executions before the first halt fetch, capped by the budget; halt wins at the cap
  function automatic void exp_run(output int cnt, output bit to);
    cnt = MAX_CYC;
    to  = 1'b1;
    for (int k = 0; k <= MAX_CYC; k++) begin
      if (exp_mem[k % 64] == HALT) begin
        cnt = k;
        to  = 1'b0;
        return;
      end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_load_len"}, load_len, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
  endtask

  task automatic stream_word(input logic [31:0] w, input bit last, output bit ok);
    bit fin;
    ok = 1'b0;
    fin = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    for (int t = 0; t < 20 && !fin; t++) begin
      @(negedge CLK);
      if (ld_ready) begin
        tick();
        ok  = 1'b1;
        fin = 1'b1;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // entered with core_rst already seen high c0 times in the current CRST window
  task automatic measure_crst(input string tag, input int c0, input bit exp_en);
    int c;
    bit fin;
    c = c0;
    fin = 1'b0;
    en_base = en_count;
    for (int t = 0; t < 10 && !fin; t++) begin
      @(negedge CLK);
      if (core_rst) c++;
      else fin = 1'b1;
    end
    check({tag, "_crst_cycles"}, c, 2);
    check({tag, "_first_en"}, core_en, exp_en);
  endtask

  task automatic start_rerun(input string tag, input bit exp_en);
    start  = 1'b1;
    reload = 1'b0;
    tick();
    start = 1'b0;
    measure_crst(tag, 0, exp_en);
  endtask

  task automatic load_prog(input int n, input bit use_last, input string tag);
    bit ok;
    int base;
    int bad;
    base = wr_cnt;
    start  = 1'b1;
    reload = 1'b1;
    tick();
    start  = 1'b0;
    reload = 1'b0;
    for (int i = 0; i < n; i++) begin
      stream_word(pw[i], use_last && (i == n - 1), ok);
      if (!ok) check({tag, "_ld_accept_wait"}, 0, 1);
      exp_mem[i] = pw[i];
    end
    @(negedge CLK);
    check({tag, "_ld_ready_off"}, ld_ready, 0);
    check({tag, "_load_len"}, load_len, n);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_last_we"}, imem_we, 1);
    check({tag, "_last_addr"}, imem_addr, n - 1);
    measure_crst(tag, core_rst ? 1 : 0, exp_mem[0] != HALT);
    check({tag, "_wr_count"}, wr_cnt - base, n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr_log[(base + i) % 256] != 6'(i) || wr_data_log[(base + i) % 256] != pw[i]) bad++;
    end
    check({tag, "_wr_content_bad"}, bad, 0);
  endtask

  task automatic run_done(input string tag);
    int  ecnt;
    bit  eto;
    bit  fin;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      if (done) fin = 1'b1;
      else @(negedge CLK);
    end
    if (!fin) check({tag, "_done_wait"}, 0, 1);
    exp_run(ecnt, eto);
    check({tag, "_done"}, done, 1);
    check({tag, "_timeout"}, timeout, eto);
    check({tag, "_cycle_cnt"}, cycle_cnt, ecnt);
    check({tag, "_en_cycles"}, en_count - en_base, ecnt);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_core_en"}, core_en, 0);
  endtask

  initial begin
    int len;
    int hpos;
    int wbase;
    bit ok;
    logic [31:0] w;

    for (int i = 0; i < 64; i++) exp_mem[i] = NOP;
    rst = 1'b0;
    clr_mem = 1'b1;
    tick();
    tick();
    clr_mem = 1'b0;
    @(negedge CLK);
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // sub, slt, beq, add: no halt anywhere, so the run ends on the budget
    pw[0] = 32'h4020_81B3;
    pw[1] = 32'h0020_A233;
    pw[2] = 32'h0020_8463;
    pw[3] = 32'h0020_82B3;
    load_prog(4, 1'b1, "t1");
    run_done("t1_budget");

    step = 1'b1;
    tick();
    step = 1'b0;
    @(negedge CLK);
    check("step_in_halt_cnt", cycle_cnt, MAX_CYC);
    check("step_in_halt_done", done, 1);

    step_mode = 1'b1;
    start_rerun("t4", 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (4) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
    end
    repeat (3) tick();
    @(negedge CLK);
    check("t4_step_en", en_count - en_base, 3);
    check("t4_step_cnt", cycle_cnt, 3);
    check("t4_step_done", done, 0);
    check("t4_step_busy", busy, 1);
    step_mode = 1'b0;
    run_done("t4_free");

    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      pw[i] = (w == HALT) ? NOP : w;
    end
    pw[5] = HALT;
    load_prog(6, 1'b1, "t2");
    run_done("t2_halt");

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        pw[i] = (w == HALT) ? NOP : w;
      end
      if ($urandom_range(0, 1) == 1) begin
        hpos = $urandom_range(0, len - 1);
        pw[hpos] = HALT;
      end
      load_prog(len, 1'b1, "rnd");
      run_done("rnd");
    end

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      pw[i] = (w == HALT) ? NOP : w;
    end
    hpos = $urandom_range(8, 30);
    pw[hpos] = HALT;
    load_prog(64, 1'b0, "t5");
    run_done("t5");

    start  = 1'b1;
    reload = 1'b1;
    tick();
    start  = 1'b0;
    reload = 1'b0;
    pw[0] = 32'h0010_0093;
    pw[1] = 32'h0020_0113;
    for (int i = 0; i < 2; i++) begin
      stream_word(pw[i], 1'b0, ok);
      if (!ok) check("t6_ld_accept_wait", 0, 1);
      exp_mem[i] = pw[i];
    end
    rst = 1'b0;
    tick();
    @(negedge CLK);
    check_reset_vals("t6_midload");
    rst = 1'b1;
    tick();
    wbase = wr_cnt;
    start_rerun("t6", exp_mem[0] != HALT);
    run_done("t6_rerun");
    check("t6_no_writes", wr_cnt - wbase, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
